hex8_mem_arb: RTL and testbench

Two-port arbiter and burst sequencer for the hex8 shared 256×8 program/data memory. It shares a single synchronous-read memory port between the hex8 core and a host loader/debug port. Arbitration is round-robin. Host requests may be multi-beat bursts with auto-incrementing, wrapping addresses. The block sits between the core's memory interface and the memory array, and is the only master of the array's port.

---
 rtl/hex8_pkg.sv | 10 +
 rtl/hex8_mem_arb_if.sv | 40 ++++
 rtl/hex8_mem_arb.sv | 106 ++++++++++
 tb/tb_hex8_mem_arb.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hex8_pkg.sv
// Shared hex8 memory-subsystem types: default widths, arbiter FSM states and
// read-return owner tags.
package hex8_pkg;
    localparam int HEX8_ADDR_W = 8;
    localparam int HEX8_DATA_W = 8;
    localparam int HEX8_LEN_W  = 4;

    typedef enum logic {IDLE, HBURST} state_t;
    typedef enum logic [1:0] {NONE, CORE, HOST} owner_t;
endpackage

// File: rtl/hex8_mem_arb_if.sv
// Bundle of core, host and memory-port signals around the hex8 memory arbiter.
// slave = arbiter view, master = surrounding system (core, host, array).
interface hex8_mem_arb_if
    import hex8_pkg::*;
#(
    parameter int ADDR_W = HEX8_ADDR_W,
    parameter int DATA_W = HEX8_DATA_W,
    parameter int LEN_W  = HEX8_LEN_W
);
    logic              core_req, core_we, core_gnt, core_rvalid;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata, core_rdata;

    logic              host_req, host_we, host_gnt, host_rvalid, host_busy;
    logic [ADDR_W-1:0] host_addr;
    logic [LEN_W-1:0]  host_len;
    logic [DATA_W-1:0] host_wdata, host_rdata;

    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  host_req, host_we, host_addr, host_len, host_wdata,
        output host_gnt, host_rvalid, host_rdata, host_busy,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output host_req, host_we, host_addr, host_len, host_wdata,
        input  host_gnt, host_rvalid, host_rdata, host_busy,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/hex8_mem_arb.sv
// Round-robin arbiter between the hex8 core and the host loader for the single
// synchronous-read memory port; host requests may be wrapping multi-beat bursts.
module hex8_mem_arb
    import hex8_pkg::*;
#(
    parameter int ADDR_W = HEX8_ADDR_W,
    parameter int DATA_W = HEX8_DATA_W,
    parameter int LEN_W  = HEX8_LEN_W
) (
    input  logic           clk,
    input  logic           reset,
    hex8_mem_arb_if.slave  bus
);
    state_t            state;
    logic              last_host, bwe;
    logic [ADDR_W-1:0] baddr;
    logic [LEN_W-1:0]  beats_left;
    owner_t            tag;
    logic [DATA_W-1:0] core_rdata_q, host_rdata_q;

    logic idle, host_win, core_win, burst_beat;

    // Grants are qualified by reset so every output is quiet while it is held.
    assign idle       = reset && (state == IDLE);
    assign host_win   = idle && bus.host_req && (!bus.core_req || !last_host);
    assign core_win   = idle && bus.core_req && !host_win;
    assign burst_beat = reset && (state == HBURST);

    assign bus.core_gnt  = core_win;
    assign bus.host_gnt  = host_win || burst_beat;
    assign bus.host_busy = host_win || burst_beat;

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (core_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.core_we;
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
        end else if (host_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.host_we;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
        end else if (burst_beat) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bwe;
            bus.mem_addr  = baddr;
            bus.mem_wdata = bus.host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_host  <= 1'b0;
            bwe        <= 1'b0;
            baddr      <= '0;
            beats_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_win) begin
                        last_host <= 1'b0;
                    end else if (host_win) begin
                        last_host <= 1'b1;
                        bwe       <= bus.host_we;
                        if (bus.host_len != '0) begin
                            baddr      <= bus.host_addr + 1'b1;
                            beats_left <= bus.host_len;
                            state      <= HBURST;
                        end
                    end
                end
                HBURST: begin
                    baddr      <= baddr + 1'b1;
                    beats_left <= beats_left - 1'b1;
                    if (beats_left == LEN_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner tag follows each read by one cycle, matching the array's latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag          <= NONE;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            tag <= NONE;
            if (bus.mem_en && !bus.mem_we) tag <= core_win ? CORE : HOST;
            if (tag == CORE) core_rdata_q <= bus.mem_rdata;
            if (tag == HOST) host_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.core_rvalid = (tag == CORE);
    assign bus.host_rvalid = (tag == HOST);
    assign bus.core_rdata  = (tag == CORE) ? bus.mem_rdata : core_rdata_q;
    assign bus.host_rdata  = (tag == HOST) ? bus.mem_rdata : host_rdata_q;
endmodule

// File: tb/tb_hex8_mem_arb.sv
// Directed bench for hex8_mem_arb with a 256x8 synchronous-read memory model.
module tb_hex8_mem_arb;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    hex8_mem_arb_if bus ();

    hex8_mem_arb #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_len = '0;
        bus.host_wdata = '0;
    endtask

    logic [7:0] burst_addr [4];

    initial begin
        burst_addr[0] = 8'hFE; burst_addr[1] = 8'hFF;
        burst_addr[2] = 8'h00; burst_addr[3] = 8'h01;
        bus.mem_rdata = '0;
        idle_inputs();

        // reset state
        tick(); tick();
        chk("rst_gnt",   {bus.core_gnt, bus.host_gnt, bus.host_busy}, 0);
        chk("rst_rv",    {bus.core_rvalid, bus.host_rvalid}, 0);
        chk("rst_mem",   {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_rdata", {bus.core_rdata, bus.host_rdata}, 0);
        reset = 1;

        // core write 0x10=0x5A, then read it back
        tick();
        bus.core_req = 1; bus.core_we = 1; bus.core_addr = 8'h10; bus.core_wdata = 8'h5A;
        #1;
        chk("cw_gnt", {bus.core_gnt, bus.host_gnt}, 2'b10);
        chk("cw_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {2'b11, 16'h105A});
        tick();
        bus.core_we = 0;
        #1;
        chk("cr_gnt", {bus.core_gnt, bus.mem_en, bus.mem_we}, 3'b110);
        tick();
        bus.core_req = 0;
        #1;
        chk("cr_rvalid", bus.core_rvalid, 1);
        chk("cr_rdata",  bus.core_rdata, 8'h5A);
        chk("cr_host",   {bus.host_gnt, bus.host_rvalid, bus.host_rdata, bus.host_busy}, 0);
        chk("cr_memidle", {bus.mem_en, bus.mem_addr, bus.mem_wdata}, 0);
        tick();
        chk("cr_pulse", {bus.core_rvalid, bus.core_rdata}, {1'b0, 8'h5A});

        // continuous contention alternates host, core, host, core
        bus.core_req = 1; bus.core_addr = 8'h30;
        bus.host_req = 1; bus.host_addr = 8'h20; bus.host_len = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_hgnt", bus.host_gnt, (i % 2 == 0));
            chk("alt_cgnt", bus.core_gnt, (i % 2 == 1));
            chk("alt_addr", bus.mem_addr, (i % 2 == 0) ? 8'h20 : 8'h30);
            if (i > 0) chk("alt_rv", {bus.host_rvalid, bus.core_rvalid},
                           (i % 2 == 1) ? 2'b10 : 2'b01);
            tick();
        end
        idle_inputs();

        // host write burst from 0xFE, 4 beats wrapping; core held off until beat 5
        for (int i = 0; i < 4; i++) begin
            bus.host_req = 1; bus.host_wdata = 8'(i + 1);
            bus.host_we = (i == 0); bus.host_len = (i == 0) ? 4'd3 : 4'd0;
            bus.host_addr = 8'hFE;
            if (i > 0) begin bus.core_req = 1; bus.core_addr = 8'hFF; end
            #1;
            chk("hw_gnt",  {bus.host_gnt, bus.core_gnt, bus.host_busy}, 3'b101);
            chk("hw_addr", bus.mem_addr, burst_addr[i]);
            chk("hw_data", {bus.mem_en, bus.mem_we, bus.mem_wdata}, {2'b11, 8'(i + 1)});
            tick();
        end
        bus.host_req = 0;
        #1;
        chk("hw_core5", {bus.core_gnt, bus.host_gnt, bus.host_busy, bus.mem_addr}, {3'b100, 8'hFF});
        tick();
        bus.core_req = 0;
        #1;
        chk("hw_wrap", {bus.core_rvalid, bus.core_rdata}, {1'b1, 8'h02});
        tick();

        // preload 0x00..0x0F with 0x30+i through the core port
        for (int i = 0; i < 16; i++) begin
            bus.core_req = 1; bus.core_we = 1; bus.core_addr = 8'(i); bus.core_wdata = 8'(8'h30 + i);
            #1;
            chk("pre_gnt", bus.core_gnt, 1);
            tick();
        end
        idle_inputs();
        tick();

        // host 16-beat read burst from 0x00
        for (int i = 0; i < 16; i++) begin
            bus.host_req = (i == 0); bus.host_len = 4'd15; bus.host_addr = 8'h00;
            #1;
            chk("hr_gnt", {bus.host_gnt, bus.host_busy, bus.mem_we, bus.mem_addr}, {3'b110, 8'(i)});
            if (i > 0) chk("hr_rv", {bus.host_rvalid, bus.host_rdata}, {1'b1, 8'(8'h30 + i - 1)});
            tick();
        end
        idle_inputs();
        #1;
        chk("hr_end", {bus.host_gnt, bus.host_busy}, 0);
        chk("hr_last", {bus.host_rvalid, bus.host_rdata}, {1'b1, 8'h3F});
        chk("hr_core", {bus.core_rvalid, bus.core_rdata}, {1'b0, 8'h02});
        tick();
        chk("hr_drop", bus.host_rvalid, 0);

        // reset on third beat of a 6-beat read burst
        for (int i = 0; i < 3; i++) begin
            bus.host_req = (i == 0); bus.host_len = 4'd5; bus.host_addr = 8'h40;
            #1;
            chk("rb_beat", {bus.host_gnt, bus.mem_addr}, {1'b1, 8'(8'h40 + i)});
            if (i < 2) tick();
        end
        reset = 0;
        #1;
        chk("rb_gnt",  {bus.host_gnt, bus.host_busy, bus.core_gnt}, 0);
        chk("rb_mem",  {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        chk("rb_rv",   {bus.host_rvalid, bus.core_rvalid, bus.host_rdata, bus.core_rdata}, 0);
        idle_inputs();
        tick();
        chk("rb_hold", {bus.host_rvalid, bus.host_gnt}, 0);
        reset = 1;
        #1;
        chk("rb_rel", {bus.host_rvalid, bus.host_gnt, bus.host_busy}, 0);
        tick();
        bus.core_req = 1; bus.core_addr = 8'h05;
        #1;
        chk("rb_cgnt", bus.core_gnt, 1);
        tick();
        bus.core_req = 0;
        #1;
        chk("rb_crd", {bus.core_rvalid, bus.core_rdata}, {1'b1, 8'h35});
        tick();

        // core read then host read: no rdata crossover
        bus.core_req = 1; bus.core_addr = 8'h03;
        #1;
        chk("x_cgnt", bus.core_gnt, 1);
        tick();
        bus.core_req = 0;
        bus.host_req = 1; bus.host_addr = 8'h0A; bus.host_len = 0;
        #1;
        chk("x_hgnt", bus.host_gnt, 1);
        chk("x_crv",  {bus.core_rvalid, bus.core_rdata, bus.host_rvalid, bus.host_rdata}, {1'b1, 8'h33, 1'b0, 8'h00});
        tick();
        bus.host_req = 0;
        #1;
        chk("x_hrv",  {bus.host_rvalid, bus.host_rdata, bus.core_rvalid, bus.core_rdata}, {1'b1, 8'h3A, 1'b0, 8'h33});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
